wam_round_ctrl: RTL and testbench
=================================

WAM_ROUND_CTRL -- requirements
Module: wam_round_ctrl

Interface
REQ-001 Parameter T_L1, default 99_999_999: level-1 terminal count.
REQ-002 Parameter T_L2, default 49_999_999: level-2 terminal count.
REQ-003 Parameter T_L3, default 24_999_999: level-3 terminal count.
REQ-004 Parameter T_L4, default 12_499_999: level-4 terminal count.
REQ-005 Parameter MAX_MISSES, default 3: misses that end a game (range 1..15).
REQ-006 CLOCK_50  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low.
REQ-008 start  in  1  single-cycle pulse; begins a game.
REQ-009 level  in  4  one-hot difficulty (0001=L1, 0010=L2, 0100=L3, 1000=L4).
REQ-010 rand_idx  in  4  random hole index from the tuner, sampled when a mole is raised.
REQ-011 hit  in  9  player buttons, already synchronous to CLOCK_50, active-high.
REQ-012 mole  out  9  one-hot lit hole, registered.
REQ-013 score  out  8  correct-hit count, registered.
REQ-014 misses  out  4  miss count, registered.
REQ-015 game_over  out  1  high in OVER state.

Function
REQ-016 FSM states SHALL be IDLE, GAP, UP, OVER.
REQ-017 The block SHALL latch level on start; level changes mid-game SHALL be ignored.
REQ-018 Timing SHALL be: L1 gap=T_L1, up=T_L1; L2 gap=T_L2, up=T_L2; L3 gap=T_L3, up=T_L2; L4 gap=T_L4, up=T_L3; any non-one-hot level SHALL use L2 timing.
REQ-019 A single 28-bit down-counter SHALL be loaded with the state's terminal count on entry to GAP or UP and SHALL decrement each cycle; the state SHALL end in the cycle the counter equals 0, so GAP lasts gap+1 cycles and UP lasts up+1 cycles.
REQ-020 IDLE/OVER: start -> GAP; score and misses cleared to 0 in the same edge.
REQ-021 GAP->UP: hole index = rand_idx if <=8, else rand_idx-9; mole SHALL show that bit from the first UP cycle until UP is left.
REQ-022 The block SHALL edge-detect hit against a registered copy (hit_q); only rising edges count; held buttons SHALL not retrigger.
REQ-023 UP, rising edge on lit hole: score+1 (saturating at 255), mole cleared, -> GAP next cycle.
REQ-024 UP, rising edge(s) only on unlit holes: misses+1 once per cycle regardless of bit count; stay in UP.
REQ-025 UP, counter reaches 0 without correct hit: misses+1, mole cleared.
REQ-026 Simultaneous correct and wrong edges SHALL count as a correct hit only; a correct hit in the counter-zero cycle SHALL win over timeout.
REQ-027 After any miss increment, if misses equals MAX_MISSES -> OVER (mole=0, game_over=1, score held); otherwise timeout -> GAP.
REQ-028 Rising edges on hit in IDLE, GAP and OVER SHALL be ignored; start in GAP/UP SHALL be ignored.

Reset
REQ-029 On reset low: state IDLE, counter 0, mole=0, score=0, misses=0, game_over=0, hit_q=0, latched level=L2, all outputs updated immediately (asynchronously).
REQ-030 Reset asserted mid-game SHALL abandon the game with no further score or miss update; after release the block SHALL wait in IDLE for start.

Verification (T_L1=7, T_L2=3, T_L3=1, T_L4=0, MAX_MISSES=3)
REQ-031 level=0010, start, rand_idx=4 -> mole=0x010 after 4 GAP cycles, held 4 cycles, then mole=0, misses=1, back to GAP.
REQ-032 level=0100, rand_idx=11, pulse hit[2] during UP -> mole=0x004 then cleared next cycle, score=1, misses=0.
REQ-033 During UP, hit[lit] and hit[other] rise in same cycle -> score+1, misses unchanged; held hit[lit] into next UP -> no second score.
REQ-034 Three consecutive timeouts -> misses=3, game_over=1, mole=0; start -> misses=0, score=0, game_over=0, GAP.
REQ-035 Reset low during UP with score=2 -> all outputs 0 immediately; after release, no activity until start.
REQ-036 level=1111 -> L2 timing; level changed to 1000 mid-game -> timing unchanged until next start.

Source files
------------

// File: rtl/wam_round_ctrl.sv
// Whack-a-mole round controller: paces mole gaps and up-times per difficulty,
// scores rising-edge button hits and ends the game after MAX_MISSES misses.
module wam_round_ctrl #(
  parameter int unsigned T_L1       = 99_999_999,
  parameter int unsigned T_L2       = 49_999_999,
  parameter int unsigned T_L3       = 24_999_999,
  parameter int unsigned T_L4       = 12_499_999,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] level,
  input  logic [3:0] rand_idx,
  input  logic [8:0] hit,
  output logic [8:0] mole,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over
);

  localparam int unsigned CW = 28;
  localparam logic [CW-1:0] C_L1 = CW'(T_L1);
  localparam logic [CW-1:0] C_L2 = CW'(T_L2);
  localparam logic [CW-1:0] C_L3 = CW'(T_L3);
  localparam logic [CW-1:0] C_L4 = CW'(T_L4);
  localparam logic [3:0]    C_MAX_MISSES = 4'(MAX_MISSES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // Gap terminal count per level; anything not one-hot falls back to L2.
  function automatic logic [CW-1:0] gap_tc(input logic [3:0] lv);
    case (lv)
      4'b0001: gap_tc = C_L1;
      4'b0010: gap_tc = C_L2;
      4'b0100: gap_tc = C_L3;
      4'b1000: gap_tc = C_L4;
      default: gap_tc = C_L2;
    endcase
  endfunction

  // Up-time terminal count per level; harder levels reuse the next-easier count.
  function automatic logic [CW-1:0] up_tc(input logic [3:0] lv);
    case (lv)
      4'b0001: up_tc = C_L1;
      4'b0010: up_tc = C_L2;
      4'b0100: up_tc = C_L2;
      4'b1000: up_tc = C_L3;
      default: up_tc = C_L2;
    endcase
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_level;
  logic [8:0]    r_hit_q;
  logic [8:0]    r_mole;
  logic [7:0]    r_score;
  logic [3:0]    r_misses;
  logic          r_game_over;

  logic [8:0]    w_rise;
  logic          w_correct;
  logic          w_any_edge;
  logic          w_cnt_zero;
  logic [3:0]    w_miss_inc;
  logic [3:0]    w_hole;
  logic [7:0]    w_score_inc;
  logic [CW-1:0] w_cnt_dec;

  assign w_rise      = hit & ~r_hit_q;
  assign w_correct   = |(w_rise & r_mole);
  assign w_any_edge  = |w_rise;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_cnt_dec   = r_cnt - CW'(1);
  assign w_miss_inc  = r_misses + 4'd1;
  assign w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
  // Fold 9..15 back onto the nine holes.
  assign w_hole      = (rand_idx <= 4'd8) ? rand_idx : rand_idx - 4'd9;

  // Round FSM with counter and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_level     <= 4'b0010;
      r_hit_q     <= '0;
      r_mole      <= '0;
      r_score     <= '0;
      r_misses    <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_hit_q <= hit;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_state     <= S_GAP;
            r_level     <= level;
            r_cnt       <= gap_tc(level);
            r_score     <= '0;
            r_misses    <= '0;
            r_game_over <= 1'b0;
          end
        end
        S_GAP: begin
          if (w_cnt_zero) begin
            r_state <= S_UP;
            r_cnt   <= up_tc(r_level);
            r_mole  <= 9'(1) << w_hole;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        S_UP: begin
          // A correct hit outranks wrong edges and the timeout in the same cycle.
          if (w_correct) begin
            r_state <= S_GAP;
            r_cnt   <= gap_tc(r_level);
            r_mole  <= '0;
            r_score <= w_score_inc;
          end else if (w_any_edge || w_cnt_zero) begin
            r_misses <= w_miss_inc;
            if (w_miss_inc == C_MAX_MISSES) begin
              r_state     <= S_OVER;
              r_cnt       <= '0;
              r_mole      <= '0;
              r_game_over <= 1'b1;
            end else if (w_cnt_zero) begin
              r_state <= S_GAP;
              r_cnt   <= gap_tc(r_level);
              r_mole  <= '0;
            end else begin
              r_cnt <= w_cnt_dec;
            end
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mole      = r_mole;
  assign score     = r_score;
  assign misses    = r_misses;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_wam_round_ctrl.sv
// Randomized and directed bench for wam_round_ctrl against a phase/remaining-cycles
// model of the game rules.
module tb_wam_round_ctrl;

  localparam int unsigned P_L1  = 7;
  localparam int unsigned P_L2  = 3;
  localparam int unsigned P_L3  = 1;
  localparam int unsigned P_L4  = 0;
  localparam int unsigned P_MAX = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_GAP  = 1;
  localparam int PH_UP   = 2;
  localparam int PH_OVER = 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] level;
  logic [3:0] rand_idx;
  logic [8:0] hit;
  logic [8:0] mole;
  logic [7:0] score;
  logic [3:0] misses;
  logic       game_over;

  always #10 CLOCK_50 = ~CLOCK_50;

  wam_round_ctrl #(
    .T_L1(P_L1), .T_L2(P_L2), .T_L3(P_L3), .T_L4(P_L4), .MAX_MISSES(P_MAX)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .level    (level),
    .rand_idx (rand_idx),
    .hit      (hit),
    .mole     (mole),
    .score    (score),
    .misses   (misses),
    .game_over(game_over)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: current phase and how many cycles of it remain.
  int         m_phase;
  int         m_left;
  logic [3:0] m_lvl;
  int         m_hole;
  int         m_score;
  int         m_misses;
  logic [8:0] m_prev;

  function automatic int gap_len(input logic [3:0] lv);
    case (lv)
      4'b0001: return P_L1 + 1;
      4'b0010: return P_L2 + 1;
      4'b0100: return P_L3 + 1;
      4'b1000: return P_L4 + 1;
      default: return P_L2 + 1;
    endcase
  endfunction

  function automatic int up_len(input logic [3:0] lv);
    case (lv)
      4'b0001: return P_L1 + 1;
      4'b0010: return P_L2 + 1;
      4'b0100: return P_L2 + 1;
      4'b1000: return P_L3 + 1;
      default: return P_L2 + 1;
    endcase
  endfunction

  function automatic logic [8:0] lit_mask();
    if (m_phase == PH_UP && m_hole >= 0) return 9'(1) << m_hole;
    return 9'd0;
  endfunction

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_left   = 0;
    m_lvl    = 4'b0010;
    m_hole   = -1;
    m_score  = 0;
    m_misses = 0;
    m_prev   = '0;
  endtask

  task automatic model_edge(input logic st, input logic [3:0] lv, input logic [3:0] idx,
                            input logic [8:0] h);
    logic [8:0] rise;
    logic       timeout;
    logic       correct;
    rise   = h & ~m_prev;
    m_prev = h;
    case (m_phase)
      PH_IDLE, PH_OVER: begin
        if (st) begin
          m_lvl    = lv;
          m_phase  = PH_GAP;
          m_left   = gap_len(lv);
          m_score  = 0;
          m_misses = 0;
        end
      end
      PH_GAP: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = PH_UP;
          m_hole  = (int'(idx) < 9) ? int'(idx) : int'(idx) - 9;
          m_left  = up_len(m_lvl);
        end
      end
      default: begin
        timeout = (m_left == 1);
        correct = ((rise >> m_hole) & 9'd1) != 9'd0;
        if (correct) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_hole  = -1;
          m_phase = PH_GAP;
          m_left  = gap_len(m_lvl);
        end else if (rise != 9'd0 || timeout) begin
          m_misses++;
          if (m_misses == P_MAX) begin
            m_phase = PH_OVER;
            m_hole  = -1;
          end else if (timeout) begin
            m_phase = PH_GAP;
            m_hole  = -1;
            m_left  = gap_len(m_lvl);
          end else begin
            m_left--;
          end
        end else begin
          m_left--;
        end
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    logic [8:0] em;
    em = (m_hole >= 0) ? 9'(1) << m_hole : 9'd0;
    check({tag, ".mole"}, 32'(mole), 32'(em));
    check({tag, ".score"}, 32'(score), 32'(m_score));
    check({tag, ".misses"}, 32'(misses), 32'(m_misses));
    check({tag, ".game_over"}, 32'(game_over), 32'(m_phase == PH_OVER));
  endtask

  // Drive one cycle of inputs, advance model and DUT by one edge, compare.
  task automatic step(input string tag, input logic st, input logic [3:0] lv,
                      input logic [3:0] idx, input logic [8:0] h);
    start    = st;
    level    = lv;
    rand_idx = idx;
    hit      = h;
    model_edge(st, lv, idx, h);
    @(posedge CLOCK_50);
    #1;
    compare_all(tag);
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    start = 1'b0;
    hit   = '0;
    reset = 1'b0;
    #1;
    check({tag, ".mole"}, 32'(mole), 32'd0);
    check({tag, ".score"}, 32'(score), 32'd0);
    check({tag, ".misses"}, 32'(misses), 32'd0);
    check({tag, ".game_over"}, 32'(game_over), 32'd0);
    model_reset();
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [8:0] h;
    int         r;
    int         guard;

    reset    = 1'b0;
    start    = 1'b0;
    level    = 4'b0010;
    rand_idx = '0;
    hit      = '0;
    model_reset();
    #1;
    check("por.mole", 32'(mole), 32'd0);
    check("por.score", 32'(score), 32'd0);
    @(posedge CLOCK_50);
    #1;
    do_reset("rst0");

    // Timeout at level 2: 4 gap cycles, 4 lit cycles, then a miss.
    step("t031", 1'b1, 4'b0010, 4'd4, 9'd0);
    for (int i = 0; i < 3; i++) step("t031g", 1'b0, 4'b0010, 4'd4, 9'd0);
    for (int i = 0; i < 4; i++) begin
      step("t031u", 1'b0, 4'b0010, 4'd4, 9'd0);
      check("t031.lit", 32'(mole), 32'h010);
    end
    step("t031t", 1'b0, 4'b0010, 4'd4, 9'd0);
    check("t031.mole_off", 32'(mole), 32'd0);
    check("t031.miss1", 32'(misses), 32'd1);

    // Level 3, index 11 folds to hole 2; a hit scores and clears the mole.
    do_reset("rst1");
    step("t032", 1'b1, 4'b0100, 4'd11, 9'd0);
    step("t032g", 1'b0, 4'b0100, 4'd11, 9'd0);
    step("t032u", 1'b0, 4'b0100, 4'd11, 9'd0);
    check("t032.lit", 32'(mole), 32'h004);
    step("t032h", 1'b0, 4'b0100, 4'd11, 9'h004);
    check("t032.cleared", 32'(mole), 32'd0);
    check("t032.score", 32'(score), 32'd1);
    check("t032.misses", 32'(misses), 32'd0);

    // Correct plus wrong edge together scores only; a held button does not rescore.
    guard = 0;
    while (m_phase != PH_UP && guard < 20) begin
      step("t033w", 1'b0, 4'b0100, 4'd11, 9'd0);
      guard++;
    end
    check("t033.reach_up", 32'(m_phase == PH_UP), 32'd1);
    step("t033h", 1'b0, 4'b0100, 4'd11, 9'h005);
    check("t033.score", 32'(score), 32'd2);
    check("t033.misses", 32'(misses), 32'd0);
    for (int i = 0; i < 8; i++) step("t033hold", 1'b0, 4'b0001, 4'd11, 9'h005);
    check("t033.no_rescore", 32'(score), 32'd2);

    // Reset during UP with score 2, then idle until start.
    check("t035.in_up", 32'(mole), 32'h004);
    do_reset("t035");
    for (int i = 0; i < 6; i++) step("t035idle", 1'b0, 4'b0001, 4'($urandom_range(0, 15)),
                                     9'($urandom_range(0, 511)));
    check("t035.still_idle", 32'(mole), 32'd0);

    // Three timeouts end the game; start clears it.
    do_reset("rst2");
    step("t034", 1'b1, 4'b0010, 4'd0, 9'd0);
    for (int i = 0; i < 30; i++) step("t034r", 1'b0, 4'b0010, 4'd0, 9'd0);
    check("t034.over", 32'(game_over), 32'd1);
    check("t034.misses", 32'(misses), 32'd3);
    check("t034.mole", 32'(mole), 32'd0);
    step("t034s", 1'b1, 4'b0010, 4'd0, 9'd0);
    check("t034.restart_over", 32'(game_over), 32'd0);
    check("t034.restart_miss", 32'(misses), 32'd0);

    // Non-one-hot level uses L2 timing; a mid-game level change is ignored.
    do_reset("rst3");
    step("t036", 1'b1, 4'b1111, 4'd7, 9'd0);
    for (int i = 0; i < 3; i++) step("t036g", 1'b0, 4'b1000, 4'd7, 9'd0);
    check("t036.gap_dark", 32'(mole), 32'd0);
    step("t036u", 1'b0, 4'b1000, 4'd7, 9'd0);
    check("t036.lit", 32'(mole), 32'h080);
    for (int i = 0; i < 12; i++) step("t036r", 1'b0, 4'b1000, 4'd7, 9'd0);

    // Fastest level with perfect hits drives the score into saturation.
    do_reset("rst4");
    step("sat", 1'b1, 4'b1000, 4'($urandom_range(0, 15)), 9'd0);
    guard = 0;
    while (m_score < 255 && guard < 1500) begin
      step("sat", 1'b0, 4'b1000, 4'($urandom_range(0, 15)), lit_mask());
      guard++;
    end
    for (int i = 0; i < 20; i++) step("sat+", 1'b0, 4'b1000, 4'($urandom_range(0, 15)), lit_mask());
    check("sat.score", 32'(score), 32'd255);

    // Random play with occasional mid-game resets.
    do_reset("rst5");
    h = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
        h = '0;
      end
      r = $urandom_range(0, 9);
      if (r < 4)       h = '0;
      else if (r < 6)  h = lit_mask();
      else if (r == 6) h = lit_mask() | 9'($urandom_range(0, 511));
      else if (r == 7) h = 9'(1) << $urandom_range(0, 8);
      r = $urandom_range(0, 15);
      step("rnd", ($urandom_range(0, 14) == 0),
           (r < 12) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), h);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
